// File: rtl/load_store_unit.sv
// Load/store initiator between the core and a word-wide single-port synchronous RAM.
// Formats load data and performs read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t                state_r;
  state_t                next_s;
  logic                  accept_s;
  logic                  req_err_s;
  logic                  is_store_r;
  logic [2:0]            funct3_r;
  logic [ADDR_WIDTH+1:0] addr_r;
  logic [31:0]           wdata_r;
  logic                  ready_r;
  logic                  we_r;
  logic                  resp_valid_r;
  logic [31:0]           resp_rdata_r;
  logic                  resp_err_r;
  logic [31:0]           mem_wdata_r;
  logic                  unused_addr_s;

  // Misaligned halves/words, reserved encodings and unsigned stores are all rejected.
  function automatic logic access_err(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = (a != 2'b00);
      3'b100:  e = st;
      3'b101:  e = st | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = w[7:0];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (f3 == 3'b000) begin
      case (a)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        2'd3:    r[31:24] = d[7:0];
        default: r        = w;
      endcase
    end else if (a[1]) begin
      r[31:16] = d[15:0];
    end else begin
      r[15:0] = d[15:0];
    end
    return r;
  endfunction

  assign accept_s      = (state_r == S_IDLE) && req_valid;
  assign req_err_s     = access_err(req_is_store, req_funct3, req_addr[1:0]);
  assign unused_addr_s = ^req_addr[31:ADDR_WIDTH+2];

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!req_valid) begin
          next_s = S_IDLE;
        end else if (req_err_s) begin
          next_s = S_RESP;
        end else if (req_is_store && (req_funct3 == 3'b010)) begin
          next_s = S_WRITE;
        end else begin
          next_s = S_ISSUE;
        end
      end
      S_ISSUE:   next_s = S_CAPTURE;
      S_CAPTURE: next_s = is_store_r ? S_WRITE : S_RESP;
      S_WRITE:   next_s = S_RESP;
      S_RESP:    next_s = S_IDLE;
      default:   next_s = S_IDLE;
    endcase
  end

  // State register, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      is_store_r   <= 1'b0;
      funct3_r     <= 3'd0;
      addr_r       <= '0;
      wdata_r      <= 32'd0;
      ready_r      <= 1'b1;
      we_r         <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
      mem_wdata_r  <= 32'd0;
    end else begin
      state_r      <= next_s;
      ready_r      <= (next_s == S_IDLE);
      we_r         <= (next_s == S_WRITE);
      resp_valid_r <= (next_s == S_RESP);
      if (accept_s) begin
        is_store_r <= req_is_store;
        funct3_r   <= req_funct3;
        addr_r     <= req_addr[ADDR_WIDTH+1:0];
        wdata_r    <= req_wdata;
      end
      // SW writes the request data directly; SB/SH write the merged captured word.
      if (accept_s && (next_s == S_WRITE)) begin
        mem_wdata_r <= req_wdata;
      end else if ((state_r == S_CAPTURE) && (next_s == S_WRITE)) begin
        mem_wdata_r <= merge_store(funct3_r, addr_r[1:0], mem_rdata, wdata_r);
      end
      if ((next_s == S_RESP) && (state_r != S_RESP)) begin
        if (state_r == S_CAPTURE) begin
          resp_rdata_r <= format_load(funct3_r, addr_r[1:0], mem_rdata);
          resp_err_r   <= 1'b0;
        end else if (state_r == S_IDLE) begin
          resp_rdata_r <= 32'd0;
          resp_err_r   <= 1'b1;
        end else begin
          resp_rdata_r <= 32'd0;
          resp_err_r   <= 1'b0;
        end
      end
    end
  end

  assign req_ready  = ready_r;
  assign mem_we     = we_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_addr   = addr_r[ADDR_WIDTH+1:2];

endmodule
